// File: rtl/sched_structs.sv
// Shared scheduler payload types for the issue-queue / register-file link.
package sched_structs;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ROB_W = 5;
    localparam int unsigned REG_W = 5;
    localparam int unsigned IDX_W = 6;

    typedef struct packed {
        logic             write;
        logic [REG_W-1:0] rd;
        logic [ROB_W-1:0] rob_index;
        logic             lookup_regfile_1;
        logic [IDX_W-1:0] reg_idx_1;
        logic             lookup_regfile_2;
        logic [IDX_W-1:0] reg_idx_2;
    } IQtoRF;

    typedef struct packed {
        logic            lookup_valid_1;
        logic            valid_1;
        logic [XLEN-1:0] val_1;
        logic            lookup_valid_2;
        logic            valid_2;
        logic [XLEN-1:0] val_2;
    } RFtoIQ;

endpackage

// File: rtl/regfile_rename_if.sv
// Issue-queue to register-file request/response link.
interface regfile_rename_if;
    import sched_structs::*;

    IQtoRF iq_req;
    RFtoIQ rf_resp;

    modport master (output iq_req, input rf_resp);
    modport slave  (input iq_req, output rf_resp);
endinterface

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename (busy/tag) status,
// commit write-back with tag-checked busy clear, bypass, and flush recovery.
module regfile_rename
    import sched_structs::*;
(
    input  logic                clk,
    input  logic                rst,
    regfile_rename_if.slave     iq,
    input  logic                commit,
    input  logic [REG_W-1:0]    commit_rd,
    input  logic [ROB_W-1:0]    commit_rob,
    input  logic [XLEN-1:0]     commit_val,
    input  logic                flush
);

    localparam int unsigned NUM_REGS = 32;

    logic [XLEN-1:0]     val_q [NUM_REGS];
    logic [ROB_W-1:0]    tag_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;

    RFtoIQ resp_c;
    logic  unused_idx_c;

    assign unused_idx_c = iq.iq_req.reg_idx_1[IDX_W-1] ^ iq.iq_req.reg_idx_2[IDX_W-1];

    // Returns {valid, val}: committed value, same-cycle commit bypass, or producing tag.
    function automatic logic [XLEN:0] lookup_f(
        input logic [REG_W-1:0] idx,
        input logic             busy,
        input logic [ROB_W-1:0] tag,
        input logic [XLEN-1:0]  val,
        input logic             cm,
        input logic [REG_W-1:0] crd,
        input logic [ROB_W-1:0] crob,
        input logic [XLEN-1:0]  cval
    );
        if (idx == '0)
            return {1'b1, XLEN'(0)};
        if (busy && cm && (crd == idx) && (tag == crob))
            return {1'b1, cval};
        if (busy)
            return {1'b0, XLEN'(tag)};
        return {1'b1, val};
    endfunction

    always_comb begin
        resp_c = '0;
        if (iq.iq_req.lookup_regfile_1) begin
            resp_c.lookup_valid_1 = 1'b1;
            {resp_c.valid_1, resp_c.val_1} = lookup_f(
                iq.iq_req.reg_idx_1[REG_W-1:0], busy_q[iq.iq_req.reg_idx_1[REG_W-1:0]],
                tag_q[iq.iq_req.reg_idx_1[REG_W-1:0]], val_q[iq.iq_req.reg_idx_1[REG_W-1:0]],
                commit, commit_rd, commit_rob, commit_val);
        end
        if (iq.iq_req.lookup_regfile_2) begin
            resp_c.lookup_valid_2 = 1'b1;
            {resp_c.valid_2, resp_c.val_2} = lookup_f(
                iq.iq_req.reg_idx_2[REG_W-1:0], busy_q[iq.iq_req.reg_idx_2[REG_W-1:0]],
                tag_q[iq.iq_req.reg_idx_2[REG_W-1:0]], val_q[iq.iq_req.reg_idx_2[REG_W-1:0]],
                commit, commit_rd, commit_rob, commit_val);
        end
    end

    // Rename is applied after commit so a same-cycle rename of the same register wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            iq.rf_resp <= '0;
            busy_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            iq.rf_resp <= resp_c;
            if (commit && (commit_rd != '0)) begin
                val_q[commit_rd] <= commit_val;
                if (tag_q[commit_rd] == commit_rob)
                    busy_q[commit_rd] <= 1'b0;
            end
            if (flush) begin
                busy_q <= '0;
            end else if (iq.iq_req.write && (iq.iq_req.rd != '0)) begin
                busy_q[iq.iq_req.rd] <= 1'b1;
                tag_q[iq.iq_req.rd]  <= iq.iq_req.rob_index;
            end
        end
    end

endmodule

// File: tb/tb_regfile_rename.sv
// Directed vector bench for regfile_rename: one record per cycle of inputs
// with the response expected after that edge.
module tb_regfile_rename;
    import sched_structs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit;
    logic [4:0]  commit_rd;
    logic [4:0]  commit_rob;
    logic [31:0] commit_val;
    logic        flush;

    regfile_rename_if iq_if ();

    regfile_rename dut (
        .clk        (clk),
        .rst        (rst),
        .iq         (iq_if.slave),
        .commit     (commit),
        .commit_rd  (commit_rd),
        .commit_rob (commit_rob),
        .commit_val (commit_val),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        IQtoRF       req;
        logic        cm;
        logic [4:0]  crd;
        logic [4:0]  crob;
        logic [31:0] cval;
        logic        fl;
        RFtoIQ       exp;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic IQtoRF mkreq(input logic l1, input logic [5:0] r1,
                                    input logic l2, input logic [5:0] r2,
                                    input logic wr, input logic [4:0] rd,
                                    input logic [4:0] rob);
        IQtoRF q;
        q.write = wr; q.rd = rd; q.rob_index = rob;
        q.lookup_regfile_1 = l1; q.reg_idx_1 = r1;
        q.lookup_regfile_2 = l2; q.reg_idx_2 = r2;
        return q;
    endfunction

    function automatic RFtoIQ mkresp(input logic lv1, input logic v1, input logic [31:0] d1,
                                     input logic lv2, input logic v2, input logic [31:0] d2);
        RFtoIQ r;
        r.lookup_valid_1 = lv1; r.valid_1 = v1; r.val_1 = d1;
        r.lookup_valid_2 = lv2; r.valid_2 = v2; r.val_2 = d2;
        return r;
    endfunction

    function automatic void add(input string nm, input logic rs, input IQtoRF q,
                                input logic cm, input logic [4:0] crd, input logic [4:0] crob,
                                input logic [31:0] cval, input logic fl, input RFtoIQ e);
        vec_t v;
        v.name = nm; v.rst = rs; v.req = q; v.cm = cm; v.crd = crd;
        v.crob = crob; v.cval = cval; v.fl = fl; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        rst            = v.rst;
        iq_if.iq_req   = v.req;
        commit         = v.cm;
        commit_rd      = v.crd;
        commit_rob     = v.crob;
        commit_val     = v.cval;
        flush          = v.fl;
        @(posedge clk);
        #1;
        total++;
        if (iq_if.rf_resp !== v.exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", v.name, iq_if.rf_resp, v.exp);
        end
    endtask

    RFtoIQ z;
    IQtoRF nq;
    vec_t  hv;

    initial begin
        z  = mkresp(0, 0, 0, 0, 0, 0);
        nq = mkreq(0, 0, 0, 0, 0, 0, 0);

        add("reset",          1, mkreq(1, 5, 1, 6, 1, 7, 1), 0, 0, 0, 0, 0, z);
        add("lookup_x5_x6",   0, mkreq(1, 5, 1, 6, 0, 0, 0), 0, 0, 0, 0, 0, mkresp(1, 1, 0, 1, 1, 0));
        add("rename_x3",      0, mkreq(0, 0, 0, 0, 1, 3, 7), 0, 0, 0, 0, 0, z);
        add("x3_busy",        0, mkreq(1, 3, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, mkresp(1, 0, 7, 0, 0, 0));
        add("commit_x3",      0, nq, 1, 3, 7, 32'hDEADBEEF, 0, z);
        add("x3_committed",   0, mkreq(1, 3, 1, 3, 0, 0, 0), 0, 0, 0, 0, 0,
            mkresp(1, 1, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF));
        add("rename_x4_t2",   0, mkreq(0, 0, 0, 0, 1, 4, 2), 0, 0, 0, 0, 0, z);
        add("rename_x4_t9",   0, mkreq(0, 0, 0, 0, 1, 4, 9), 0, 0, 0, 0, 0, z);
        add("stale_commit",   0, nq, 1, 4, 2, 32'h11, 0, z);
        add("x4_still_busy",  0, mkreq(1, 4, 1, 6'h24, 0, 0, 0), 0, 0, 0, 0, 0, mkresp(1, 0, 9, 1, 0, 9));
        add("commit_x4_t9",   0, nq, 1, 4, 9, 32'h22, 0, z);
        add("x4_committed",   0, mkreq(1, 4, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, mkresp(1, 1, 32'h22, 0, 0, 0));
        add("rename_x1_t4",   0, mkreq(0, 0, 0, 0, 1, 1, 4), 0, 0, 0, 0, 0, z);
        add("hazard_bypass",  0, mkreq(1, 1, 1, 1, 1, 1, 6), 1, 1, 4, 32'h55, 0,
            mkresp(1, 1, 32'h55, 1, 1, 32'h55));
        add("hazard_renamed", 0, mkreq(1, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, mkresp(1, 0, 6, 0, 0, 0));
        add("x0_write",       0, mkreq(1, 0, 0, 0, 1, 0, 3), 1, 0, 3, 32'hFF, 0, mkresp(1, 1, 0, 0, 0, 0));
        add("x0_lookup",      0, mkreq(1, 0, 1, 0, 0, 0, 0), 0, 0, 0, 0, 0, mkresp(1, 1, 0, 1, 1, 0));
        add("rename_x8",      0, mkreq(0, 0, 0, 0, 1, 8, 10), 0, 0, 0, 0, 0, z);
        add("rename_x9",      0, mkreq(1, 8, 0, 0, 1, 9, 11), 0, 0, 0, 0, 0, mkresp(1, 0, 10, 0, 0, 0));
        add("flush_cycle",    0, mkreq(1, 9, 1, 8, 1, 10, 12), 0, 0, 0, 0, 1, mkresp(1, 0, 11, 1, 0, 10));
        add("flush_x8_x9",    0, mkreq(1, 8, 1, 9, 0, 0, 0), 0, 0, 0, 0, 0, mkresp(1, 1, 0, 1, 1, 0));
        add("flush_x10",      0, mkreq(1, 10, 1, 3, 0, 0, 0), 0, 0, 0, 0, 0,
            mkresp(1, 1, 0, 1, 1, 32'hDEADBEEF));
        add("rename_x12",     0, mkreq(0, 0, 0, 0, 1, 12, 5), 0, 0, 0, 0, 0, z);
        add("flush_commit",   0, mkreq(1, 12, 0, 0, 0, 0, 0), 1, 12, 5, 32'h77, 1, mkresp(1, 1, 32'h77, 0, 0, 0));
        add("x12_after",      0, mkreq(0, 0, 1, 12, 0, 0, 0), 0, 0, 0, 0, 0, mkresp(0, 0, 0, 1, 1, 32'h77));
        add("rename_x4_t3",   0, mkreq(0, 0, 0, 0, 1, 4, 3), 0, 0, 0, 0, 0, z);
        add("no_bypass_stale",0, mkreq(1, 4, 0, 0, 0, 0, 0), 1, 4, 9, 32'h33, 0, mkresp(1, 0, 3, 0, 0, 0));
        add("x4_busy_t3",     0, mkreq(1, 4, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, mkresp(1, 0, 3, 0, 0, 0));
        add("commit_x4_t3",   0, nq, 1, 4, 3, 32'h44, 0, z);
        add("x4_val44",       0, mkreq(0, 0, 1, 4, 0, 0, 0), 0, 0, 0, 0, 0, mkresp(0, 0, 0, 1, 1, 32'h44));
        add("mid_reset",      1, mkreq(1, 3, 1, 4, 0, 0, 0), 1, 3, 1, 32'h99, 0, z);
        add("after_reset",    0, mkreq(1, 3, 1, 4, 0, 0, 0), 0, 0, 0, 0, 0, mkresp(1, 1, 0, 1, 1, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // Lookup racing a rename sees pre-rename state; response lasts one cycle.
        hv = vecs[0];
        hv.rst = 0; hv.cm = 0; hv.fl = 0;
        hv.name = "race_rename";  hv.req = mkreq(1, 20, 0, 0, 1, 20, 30); hv.exp = mkresp(1, 1, 0, 0, 0, 0);
        apply(hv);
        hv.name = "x20_busy";     hv.req = mkreq(0, 0, 1, 20, 0, 0, 0);   hv.exp = mkresp(0, 0, 0, 1, 0, 30);
        apply(hv);
        hv.name = "resp_dropped"; hv.req = nq;                            hv.exp = z;
        apply(hv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
